// File: rtl/bec_pkg.sv
// Shared types and constants for the burst-error channel model.
//   bec_mode_e  : error-injection mode (shadow config)
//   bec_state_e : per-lane Gilbert chain state
//   bec_cfg_t   : shadow configuration payload handed to every lane
//   CNT_W/PC_W  : statistics counter width / per-cycle popcount width
package bec_pkg;

  localparam int unsigned CNT_W = 48;
  // Popcount of up to 16 lanes.
  localparam int unsigned PC_W  = 5;

  typedef enum logic [1:0] {
    BEC_BYPASS = 2'd0,
    BEC_ALT    = 2'd1,
    BEC_RAND   = 2'd2,
    BEC_PLUS1  = 2'd3
  } bec_mode_e;

  typedef enum logic {
    BEC_GOOD  = 1'b0,
    BEC_BURST = 1'b1
  } bec_state_e;

  typedef struct packed {
    bec_mode_e   mode;
    logic [63:0] rser;
    logic [63:0] epf;
  } bec_cfg_t;

  // Saturating accumulate; the extra sum bit flags overflow past 2^CNT_W-1.
  function automatic logic [CNT_W-1:0] cnt_sat_add(input logic [CNT_W-1:0] cnt,
                                                   input logic [PC_W-1:0]  inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/bec_lane.sv
// One channel lane: 64-bit combined-Tausworthe URNG, GOOD/BURST Markov chain
// and symbol error arithmetic.
//   clk, rst          clock, synchronous active-high reset
//   en                advance: consume sym_in, step URNG and chain
//   sym_in            input symbol
//   cfg               shadow configuration (mode, rser, epf)
//   seed0/1/2         URNG component seeds, loaded on reset
//   sym_out, err      registered output symbol / corrupted flag
//   err_ev_c          this cycle's symbol is being corrupted
//   burst_ev_c        this cycle enters a burst
module bec_lane
  import bec_pkg::*;
#(
  parameter int unsigned SYM_W  = 2,
  parameter bit          SAT_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SYM_W-1:0] sym_in,
  input  bec_cfg_t         cfg,
  input  logic [63:0]      seed0,
  input  logic [63:0]      seed1,
  input  logic [63:0]      seed2,
  output logic [SYM_W-1:0] sym_out,
  output logic             err,
  output logic             err_ev_c,
  output logic             burst_ev_c
);

  localparam logic [SYM_W-1:0] SYM_MAX = '1;

  logic [63:0] s1, s2, s3;
  logic [63:0] s1_nxt_c, s2_nxt_c, s3_nxt_c;
  logic [63:0] rnd_c;
  bec_state_e  state;
  logic        err_sign;
  logic        plus_c;
  logic [SYM_W-1:0] sym_plus_c, sym_minus_c, sym_err_c;

  // Three Tausworthe components (lfsr258 components 1..3), XOR-combined.
  always_comb begin
    s1_nxt_c = ((s1 & 64'hFFFF_FFFF_FFFF_FFFE) << 10) ^ (((s1 << 1)  ^ s1) >> 53);
    s2_nxt_c = ((s2 & 64'hFFFF_FFFF_FFFF_FE00) << 5)  ^ (((s2 << 24) ^ s2) >> 50);
    s3_nxt_c = ((s3 & 64'hFFFF_FFFF_FFFF_F000) << 29) ^ (((s3 << 3)  ^ s3) >> 23);
    rnd_c    = s1 ^ s2 ^ s3;
  end

  // Error direction and +/-1 arithmetic (wrap or clamp).
  always_comb begin
    plus_c = 1'b1;
    case (cfg.mode)
      BEC_ALT:  plus_c = ~err_sign;
      BEC_RAND: plus_c = rnd_c[0];
      default:  plus_c = 1'b1;
    endcase
    sym_plus_c  = (SAT_EN && sym_in == SYM_MAX) ? sym_in : sym_in + SYM_W'(1);
    sym_minus_c = (SAT_EN && sym_in == '0)      ? sym_in : sym_in - SYM_W'(1);
    sym_err_c   = plus_c ? sym_plus_c : sym_minus_c;
  end

  // Same-cycle events feeding the aggregate statistics.
  always_comb begin
    err_ev_c   = en && (cfg.mode != BEC_BYPASS) && (state == BEC_BURST);
    burst_ev_c = en && (cfg.mode != BEC_BYPASS) && (state == BEC_GOOD) && (rnd_c < cfg.rser);
  end

  // Chain state, URNG state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= seed0;
      s2       <= seed1;
      s3       <= seed2;
      state    <= BEC_GOOD;
      err_sign <= 1'b0;
      sym_out  <= '0;
      err      <= 1'b0;
    end else if (en) begin
      s1 <= s1_nxt_c;
      s2 <= s2_nxt_c;
      s3 <= s3_nxt_c;
      if (cfg.mode == BEC_BYPASS) begin
        sym_out <= sym_in;
        err     <= 1'b0;
        state   <= BEC_GOOD;
      end else begin
        case (state)
          BEC_GOOD: begin
            sym_out <= sym_in;
            err     <= 1'b0;
            // The error lands on the following symbol.
            if (rnd_c < cfg.rser) state <= BEC_BURST;
          end
          default: begin
            sym_out <= sym_err_c;
            err     <= 1'b1;
            if (cfg.mode == BEC_ALT) err_sign <= ~err_sign;
            if (rnd_c >= cfg.epf)   state    <= BEC_GOOD;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/burst_err_channel_mc.sv
// Multi-lane Gilbert burst-error channel placed between symbol source and
// decoder. Holds the shadow configuration, the lane array, and aggregate
// error statistics.
//   clk, rst                 clock, synchronous active-high reset
//   en                       consume sym_in and step every lane
//   sym_in / sym_out         LANES*SYM_W symbols, lane i at [i*SYM_W +: SYM_W]
//   cfg_ld, cfg_mode,
//   cfg_rser, cfg_epf        shadow config load (used from the next cycle)
//   rng_seed0/1/2            URNG seeds, lane i uses seed ^ SEED_BASE*(i+1)
//   valid, err_mask          output valid / per-lane corrupted flags
//   err_sym_cnt, burst_cnt   saturating statistics
// Build option: BEC_STATS_EN enables the statistics counters; without it
// both counters read 0.
module burst_err_channel_mc
  import bec_pkg::*;
#(
  parameter int unsigned LANES     = 4,
  parameter int unsigned SYM_W     = 2,
  parameter bit          SAT_EN    = 1'b0,
  parameter logic [63:0] SEED_BASE = 64'h9372_85FF_3748_6972
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [LANES*SYM_W-1:0] sym_in,
  input  logic                   cfg_ld,
  input  logic [1:0]             cfg_mode,
  input  logic [63:0]            cfg_rser,
  input  logic [63:0]            cfg_epf,
  input  logic [63:0]            rng_seed0,
  input  logic [63:0]            rng_seed1,
  input  logic [63:0]            rng_seed2,
  output logic [LANES*SYM_W-1:0] sym_out,
  output logic                   valid,
  output logic [LANES-1:0]       err_mask,
  output logic [CNT_W-1:0]       err_sym_cnt,
  output logic [CNT_W-1:0]       burst_cnt
);

  bec_cfg_t         cfg;
  logic [LANES-1:0] err_ev;
  logic [LANES-1:0] burst_ev;

  // Shadow configuration; the cycle carrying cfg_ld still sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg   <= '{mode: BEC_BYPASS, rser: '0, epf: '0};
      valid <= 1'b0;
    end else begin
      if (cfg_ld) cfg <= '{mode: bec_mode_e'(cfg_mode), rser: cfg_rser, epf: cfg_epf};
      valid <= en;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bec_lane #(
      .SYM_W  (SYM_W),
      .SAT_EN (SAT_EN)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .sym_in     (sym_in[i*SYM_W +: SYM_W]),
      .cfg        (cfg),
      .seed0      (rng_seed0 ^ (SEED_BASE * 64'(i + 1))),
      .seed1      (rng_seed1 ^ (SEED_BASE * 64'(i + 1))),
      .seed2      (rng_seed2 ^ (SEED_BASE * 64'(i + 1))),
      .sym_out    (sym_out[i*SYM_W +: SYM_W]),
      .err        (err_mask[i]),
      .err_ev_c   (err_ev[i]),
      .burst_ev_c (burst_ev[i])
    );
  end

`ifdef BEC_STATS_EN
  logic [PC_W-1:0] err_pc_c, burst_pc_c;

  // Same-cycle event popcounts across lanes.
  always_comb begin
    err_pc_c   = '0;
    burst_pc_c = '0;
    for (int i = 0; i < LANES; i++) begin
      err_pc_c   = err_pc_c   + PC_W'(err_ev[i]);
      burst_pc_c = burst_pc_c + PC_W'(burst_ev[i]);
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sym_cnt <= '0;
      burst_cnt   <= '0;
    end else begin
      err_sym_cnt <= cnt_sat_add(err_sym_cnt, err_pc_c);
      burst_cnt   <= cnt_sat_add(burst_cnt, burst_pc_c);
    end
  end
`else
  logic unused_ev;
  assign unused_ev   = ^{err_ev, burst_ev};
  assign err_sym_cnt = '0;
  assign burst_cnt   = '0;
`endif

endmodule

// File: tb/tb_burst_err_channel_mc.sv
// Directed bench for burst_err_channel_mc: a 4-lane wrapping instance and a
// 2-lane saturating instance sharing clock, reset and configuration.
module tb_burst_err_channel_mc;

`ifdef BEC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [63:0] ONES = '1;

  logic        clk = 1'b0;
  logic        rst, en, en1, cfg_ld;
  logic [7:0]  sym_in;
  logic [3:0]  sym_in1;
  logic [1:0]  cfg_mode;
  logic [63:0] cfg_rser, cfg_epf;
  logic [63:0] seed0, seed1, seed2;

  logic [7:0]  sym_out;
  logic        valid;
  logic [3:0]  err_mask;
  logic [47:0] err_sym_cnt, burst_cnt;
  logic [3:0]  sym_out1;
  logic        valid1;
  logic [1:0]  err_mask1;
  logic [47:0] err_sym_cnt1, burst_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  burst_err_channel_mc #(.LANES(4), .SYM_W(2), .SAT_EN(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .sym_in(sym_in), .cfg_ld(cfg_ld),
    .cfg_mode(cfg_mode), .cfg_rser(cfg_rser), .cfg_epf(cfg_epf),
    .rng_seed0(seed0), .rng_seed1(seed1), .rng_seed2(seed2),
    .sym_out(sym_out), .valid(valid), .err_mask(err_mask),
    .err_sym_cnt(err_sym_cnt), .burst_cnt(burst_cnt)
  );

  burst_err_channel_mc #(.LANES(2), .SYM_W(2), .SAT_EN(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .en(en1), .sym_in(sym_in1), .cfg_ld(cfg_ld),
    .cfg_mode(cfg_mode), .cfg_rser(cfg_rser), .cfg_epf(cfg_epf),
    .rng_seed0(seed0), .rng_seed1(seed1), .rng_seed2(seed2),
    .sym_out(sym_out1), .valid(valid1), .err_mask(err_mask1),
    .err_sym_cnt(err_sym_cnt1), .burst_cnt(burst_cnt1)
  );

  function automatic logic [47:0] cexp(input int v);
    return STATS ? 48'(v) : 48'd0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [1:0] mode, input logic [63:0] rser, input logic [63:0] epf);
    cfg_mode = mode; cfg_rser = rser; cfg_epf = epf; cfg_ld = 1'b1;
    tick();
    cfg_ld = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; en1 = 1'b0; cfg_ld = 1'b0;
    sym_in = 8'h00; sym_in1 = 4'h0;
    cfg_mode = 2'd0; cfg_rser = '0; cfg_epf = '0;
    seed0 = 64'h0123_4567_89AB_CDEF; seed1 = 64'hFEDC_BA98_7654_3210; seed2 = 64'h0F1E_2D3C_4B5A_6978;
    tick(); tick();
    checks++;
    if (sym_out !== 8'h00 || valid !== 1'b0 || err_mask !== 4'h0) begin
      errors++; $display("FAIL reset_out: got sym=%h v=%b m=%h exp 00 0 0", sym_out, valid, err_mask);
    end
    checks++;
    if (err_sym_cnt !== 48'd0 || burst_cnt !== 48'd0) begin
      errors++; $display("FAIL reset_cnt: got err=%0d burst=%0d exp 0 0", err_sym_cnt, burst_cnt);
    end
    checks++;
    if (sym_out1 !== 4'h0 || valid1 !== 1'b0 || err_mask1 !== 2'b00) begin
      errors++; $display("FAIL reset_sat: got sym=%h v=%b m=%b exp 0 0 0", sym_out1, valid1, err_mask1);
    end
    rst = 1'b0;
  endtask

  task automatic test_bypass;
    logic [7:0] vec [4];
    vec[0] = 8'h1B; vec[1] = 8'hE4; vec[2] = 8'hFF; vec[3] = 8'h00;
    en = 1'b1;
    sym_in = vec[0];
    load_cfg(2'd0, ONES, ONES);
    for (int k = 0; k < 4; k++) begin
      sym_in = vec[k];
      tick();
      checks++;
      if (sym_out !== vec[k] || err_mask !== 4'h0 || valid !== 1'b1) begin
        errors++; $display("FAIL bypass_%0d: got sym=%h m=%h v=%b exp %h 0 1", k, sym_out, err_mask, valid, vec[k]);
      end
    end
    checks++;
    if (err_sym_cnt !== 48'd0 || burst_cnt !== 48'd0) begin
      errors++; $display("FAIL bypass_cnt: got err=%0d burst=%0d exp 0 0", err_sym_cnt, burst_cnt);
    end
  endtask

  task automatic test_alt;
    logic [7:0] exp_sym;
    en = 1'b0;
    load_cfg(2'd1, ONES, ONES);
    en = 1'b1; sym_in = 8'h55;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_sym = (k == 0) ? 8'h55 : ((k % 2 == 1) ? 8'hAA : 8'h00);
      checks++;
      if (sym_out !== exp_sym || err_mask !== ((k == 0) ? 4'h0 : 4'hF)) begin
        errors++; $display("FAIL alt_%0d: got sym=%h m=%h exp %h", k, sym_out, err_mask, exp_sym);
      end
      checks++;
      if (err_sym_cnt !== cexp(4 * k) || burst_cnt !== cexp(4)) begin
        errors++; $display("FAIL alt_cnt_%0d: got err=%0d burst=%0d exp %0d %0d", k, err_sym_cnt, burst_cnt, cexp(4 * k), cexp(4));
      end
    end
    // Switch to BYPASS while enabled: this cycle still corrupts under ALT.
    cfg_mode = 2'd0; cfg_ld = 1'b1;
    tick();
    cfg_ld = 1'b0;
    checks++;
    if (sym_out !== 8'h00 || err_mask !== 4'hF || err_sym_cnt !== cexp(16)) begin
      errors++; $display("FAIL alt_oldcfg: got sym=%h m=%h err=%0d exp 00 f %0d", sym_out, err_mask, err_sym_cnt, cexp(16));
    end
    tick();
    checks++;
    if (sym_out !== 8'h55 || err_mask !== 4'h0 || err_sym_cnt !== cexp(16)) begin
      errors++; $display("FAIL alt_newcfg: got sym=%h m=%h err=%0d exp 55 0 %0d", sym_out, err_mask, err_sym_cnt, cexp(16));
    end
  endtask

  task automatic test_plus1_wrap;
    en = 1'b0;
    load_cfg(2'd3, ONES, 64'd0);
    en = 1'b1; sym_in = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (sym_out !== ((k % 2 == 0) ? 8'hFF : 8'h00) || err_mask !== ((k % 2 == 0) ? 4'h0 : 4'hF)) begin
        errors++; $display("FAIL plus1_%0d: got sym=%h m=%h", k, sym_out, err_mask);
      end
      checks++;
      if (burst_cnt !== cexp(4 + 4 * (k / 2 + 1)) || err_sym_cnt !== cexp(16 + 4 * ((k + 1) / 2))) begin
        errors++; $display("FAIL plus1_cnt_%0d: got burst=%0d err=%0d exp %0d %0d", k, burst_cnt, err_sym_cnt,
                           cexp(4 + 4 * (k / 2 + 1)), cexp(16 + 4 * ((k + 1) / 2)));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_saturate;
    logic [3:0] exp_sym [5];
    logic [1:0] exp_m   [5];
    exp_sym[0] = 4'h0; exp_sym[1] = 4'h5; exp_sym[2] = 4'h0; exp_sym[3] = 4'hF; exp_sym[4] = 4'hA;
    exp_m[0] = 2'b00; exp_m[1] = 2'b11; exp_m[2] = 2'b11; exp_m[3] = 2'b11; exp_m[4] = 2'b11;
    en = 1'b0; en1 = 1'b0;
    load_cfg(2'd1, ONES, ONES);
    en1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sym_in1 = (k < 3) ? 4'h0 : 4'hF;
      tick();
      checks++;
      if (sym_out1 !== exp_sym[k] || err_mask1 !== exp_m[k]) begin
        errors++; $display("FAIL sat_%0d: got sym=%h m=%b exp %h %b", k, sym_out1, err_mask1, exp_sym[k], exp_m[k]);
      end
    end
    checks++;
    if (err_sym_cnt1 !== cexp(8) || burst_cnt1 !== cexp(2)) begin
      errors++; $display("FAIL sat_cnt: got err=%0d burst=%0d exp %0d %0d", err_sym_cnt1, burst_cnt1, cexp(8), cexp(2));
    end
    en1 = 1'b0;
    tick();
    checks++;
    if (valid1 !== 1'b0 || sym_out1 !== 4'hA || err_mask1 !== 2'b11) begin
      errors++; $display("FAIL sat_hold: got v=%b sym=%h m=%b exp 0 a 11", valid1, sym_out1, err_mask1);
    end
  endtask

  task automatic test_freeze_reset;
    en = 1'b1; sym_in = 8'h55;
    tick(); tick();
    checks++;
    if (sym_out !== 8'hAA || err_mask !== 4'hF || err_sym_cnt !== cexp(28) || burst_cnt !== cexp(16)) begin
      errors++; $display("FAIL frz_pre: got sym=%h m=%h err=%0d burst=%0d", sym_out, err_mask, err_sym_cnt, burst_cnt);
    end
    en = 1'b0; sym_in = 8'h00;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (valid !== 1'b0 || sym_out !== 8'hAA || err_mask !== 4'hF || err_sym_cnt !== cexp(28)) begin
        errors++; $display("FAIL frz_hold_%0d: got v=%b sym=%h m=%h err=%0d", k, valid, sym_out, err_mask, err_sym_cnt);
      end
    end
    // Resuming continues the frozen burst with the frozen sign (-1).
    en = 1'b1; sym_in = 8'h55;
    tick();
    checks++;
    if (sym_out !== 8'h00 || err_mask !== 4'hF || valid !== 1'b1 || err_sym_cnt !== cexp(32)) begin
      errors++; $display("FAIL frz_resume: got sym=%h m=%h v=%b err=%0d exp 00 f 1 %0d", sym_out, err_mask, valid, err_sym_cnt, cexp(32));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (sym_out !== 8'h00 || valid !== 1'b0 || err_mask !== 4'h0 || err_sym_cnt !== 48'd0 || burst_cnt !== 48'd0) begin
      errors++; $display("FAIL midburst_rst: got sym=%h v=%b m=%h err=%0d burst=%0d", sym_out, valid, err_mask, err_sym_cnt, burst_cnt);
    end
    en = 1'b0;
    load_cfg(2'd1, ONES, ONES);
    en = 1'b1;
    tick();
    checks++;
    if (sym_out !== 8'h55 || err_mask !== 4'h0 || burst_cnt !== cexp(4)) begin
      errors++; $display("FAIL rst_good: got sym=%h m=%h burst=%0d exp 55 0 %0d", sym_out, err_mask, burst_cnt, cexp(4));
    end
    tick();
    checks++;
    if (sym_out !== 8'hAA || err_mask !== 4'hF || err_sym_cnt !== cexp(4)) begin
      errors++; $display("FAIL rst_sign: got sym=%h m=%h err=%0d exp aa f %0d", sym_out, err_mask, err_sym_cnt, cexp(4));
    end
    cfg_mode = 2'd0; cfg_ld = 1'b1;
    tick();
    cfg_ld = 1'b0;
    checks++;
    if (sym_out !== 8'h00 || err_mask !== 4'hF || err_sym_cnt !== cexp(8)) begin
      errors++; $display("FAIL ld_en_old: got sym=%h m=%h err=%0d exp 00 f %0d", sym_out, err_mask, err_sym_cnt, cexp(8));
    end
    tick();
    checks++;
    if (sym_out !== 8'h55 || err_mask !== 4'h0 || err_sym_cnt !== cexp(8) || burst_cnt !== cexp(4)) begin
      errors++; $display("FAIL ld_en_new: got sym=%h m=%h err=%0d burst=%0d", sym_out, err_mask, err_sym_cnt, burst_cnt);
    end
  endtask

  task automatic test_rand;
    logic       ok;
    logic [1:0] got, lane_p, lane_m;
    en = 1'b0;
    load_cfg(2'd2, 64'd0, ONES);
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sym_in = 8'(k * 8'h2D + 8'h13);
      tick();
      checks++;
      if (sym_out !== 8'(k * 8'h2D + 8'h13) || err_mask !== 4'h0) begin
        errors++; $display("FAIL rser0_%0d: got sym=%h m=%h exp %h 0", k, sym_out, err_mask, 8'(k * 8'h2D + 8'h13));
      end
    end
    en = 1'b0;
    load_cfg(2'd2, ONES, ONES);
    en = 1'b1; sym_in = 8'hE4;
    tick();
    checks++;
    if (sym_out !== 8'hE4 || err_mask !== 4'h0) begin
      errors++; $display("FAIL rand_entry: got sym=%h m=%h exp e4 0", sym_out, err_mask);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      ok = (err_mask === 4'hF);
      for (int i = 0; i < 4; i++) begin
        got    = sym_out[2*i +: 2];
        lane_p = 2'(i + 1);
        lane_m = 2'(i + 3);
        if (got !== lane_p && got !== lane_m) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
        errors++; $display("FAIL rand_%0d: got sym=%h m=%h exp lanes in+/-1 of e4, mask f", k, sym_out, err_mask);
      end
    end
    checks++;
    if (err_sym_cnt !== cexp(24) || burst_cnt !== cexp(8)) begin
      errors++; $display("FAIL rand_cnt: got err=%0d burst=%0d exp %0d %0d", err_sym_cnt, burst_cnt, cexp(24), cexp(8));
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_alt();
    test_plus1_wrap();
    test_saturate();
    test_freeze_reset();
    test_rand();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
